dpram_fifo_ctrl: RTL and testbench
==================================

Name: dpram_fifo_ctrl

Overview:
- Stream-to-RAM controller that turns the dual-port RAM (16 x 8, ports A/B, common clk) into a first-word-fall-through FIFO.
- Sits directly upstream of the dpram: drives port A as the write-only port and port B as the read-only port.
- Consumes doutb and presents the data on a valid/ready output stream.
- Provides 1 word/cycle sustained throughput in both directions.

Parameters:
- DATA_W, 8, data width; matches RAM dina/douta.
- ADDR_W, 4, RAM address width; FIFO RAM depth DEPTH = 2**ADDR_W = 16.

Ports:
- clk  in  1  system clock, also drives dpram clk.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  controller can accept; equals !full.
- s_data  in  DATA_W  upstream word.
- m_valid  out  1  head word valid.
- m_ready  in  1  downstream consumes head.
- m_data  out  DATA_W  head word.
- ram_wea  out  1  to dpram wea.
- ram_addra  out  ADDR_W  to dpram addra.
- ram_dina  out  DATA_W  to dpram dina.
- ram_web  out  1  to dpram web; constant 0.
- ram_addrb  out  ADDR_W  to dpram addrb.
- ram_doutb  in  DATA_W  from dpram doutb.
- full  out  1  RAM occupancy == DEPTH.
- empty  out  1  total occupancy == 0.
- count  out  ADDR_W+2  total words held (RAM + in-flight + output buffer), max DEPTH+2.

Behaviour:
- Reset (async assert, sync release): wr_ptr = rd_ptr = 0, ram_used = 0, in-flight flag = 0, output buffer empty. Outputs at reset: s_ready = 1, m_valid = 0, m_data = 0, full = 0, empty = 1, count = 0, ram_wea = 0, ram_addra = 0, ram_dina = 0, ram_web = 0, ram_addrb = 0.
- RAM timing (fixed): write occurs at the clock edge while wea = 1; doutb is registered, valid one cycle after addrb is presented.
- Push: push = s_valid && s_ready. Write port is combinational: ram_wea = push, ram_addra = wr_ptr, ram_dina = s_data. On the edge, wr_ptr++ (wraps 15 -> 0) and ram_used++.
- Read issue: rd_issue = (ram_used != 0) && (obuf_cnt + inflight - pop < 2), where pop = m_valid && m_ready. ram_addrb = rd_ptr (held when not issuing). On the edge, rd_ptr++ (wraps), ram_used--, inflight <= 1; otherwise inflight <= 0.
- Capture: when inflight = 1, ram_doutb is written into the 2-entry output buffer (in-order skid). Head entry drives m_data; m_valid = obuf_cnt != 0. A pop and a capture in the same cycle are both honoured.
- Latency: a word pushed at edge E0 into an empty controller is read at E1, captured at E2, and m_valid = 1 in the cycle after E2. This is 3 cycles push-to-valid.
- Simultaneous push + rd_issue: ram_used is unchanged. A read never targets the slot being written, because ram_used counts only words written at prior edges.
- Full: ram_used == DEPTH -> s_ready = 0 and push is ignored; s_data is don't-care.
- Empty: no read issue; m_data holds its last value while m_valid = 0.
- count updates every edge: +push, -pop.
- Reset mid-operation: all state clears immediately, any in-flight read is discarded, and stale RAM contents become unreachable.
- m_data and m_valid must not change while m_valid && !m_ready.

Optional Feature:
- DPRAM_FIFO_AFULL_EN defined: adds parameter AF_LEVEL (default 12) and output port almost_full (1 bit, reset 0).
  - almost_full is registered and equals (ram_used >= AF_LEVEL) after each edge.
- Macro undefined: no AF_LEVEL parameter, no almost_full port, no related logic.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> s_ready = 1, empty = 1, m_valid = 0, count = 0, ram_web = 0 throughout.
- Single word: push 0xA5 -> ram_wea = 1, ram_addra = 0 that cycle; ram_addrb = 0 one cycle later; m_valid = 1 with m_data = 0xA5 three cycles after the push; pop -> empty = 1, count = 0.
- Fill with m_ready = 0: push 0x00..0x11 (18 words) -> RAM holds 16 and the buffer holds 2. full = 1 and s_ready = 0 after the 18th push; count = 18. Then drain with m_ready = 1 -> data out 0x00..0x11 in order, no duplicates.
- Pointer wrap under streaming: 40 consecutive pushes with m_ready = 1 -> exactly 1 word/cycle out after 3-cycle latency; values in order; ram_addra and ram_addrb wrap 15 -> 0.
- Backpressure: toggle m_ready every cycle while pushing continuously -> no loss or reorder; m_data stable while m_valid && !m_ready.
- Mid-operation reset: 5 words queued, one read in flight, assert rst -> m_valid = 0 and count = 0 immediately. The next word pushed after release is the first word output. With DPRAM_FIFO_AFULL_EN, almost_full rises when ram_used reaches 12.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
//
// Turns a 16 x 8 dual-port RAM (registered read on port B, common clock)
// into a first-word-fall-through FIFO. Port A is used for writes only and
// port B for reads only. A 2-entry output buffer absorbs the one-cycle RAM
// read latency. With it, the controller sustains one word per cycle in and
// one word per cycle out.
//
// Ports:
//   clk, rst               system clock; asynchronous active-high reset
//   s_valid/s_ready/s_data upstream stream in (s_ready = !full)
//   m_valid/m_ready/m_data downstream stream out (head of the FIFO)
//   ram_wea/addra/dina     RAM port A (write)
//   ram_web/addrb          RAM port B (read; web is always 0)
//   ram_doutb              RAM port B registered read data
//   full                   RAM occupancy == DEPTH
//   empty                  nothing held anywhere (RAM, in flight, buffer)
//   count                  total words held, 0 .. DEPTH+2
//
// Optional build macro DPRAM_FIFO_AFULL_EN adds parameter AF_LEVEL and the
// registered output almost_full = (RAM occupancy >= AF_LEVEL).

module dpram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
`ifdef DPRAM_FIFO_AFULL_EN
    ,
    parameter int AF_LEVEL = 12
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W+1:0] count
`ifdef DPRAM_FIFO_AFULL_EN
    ,
    output logic              almost_full
`endif
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_used;      // words in RAM, written at prior edges
    logic [ADDR_W:0]   ram_used_nxt;
    logic              inflight;      // a RAM read was issued last edge
    logic [DATA_W-1:0] obuf0;         // head entry, drives m_data
    logic [DATA_W-1:0] obuf1;
    logic [1:0]        obuf_cnt;

    logic              push;
    logic              pop;
    logic              rd_issue;
    logic [2:0]        slots_claimed;

    // ram_used never exceeds DEPTH = 2**ADDR_W, so its MSB alone means full.
    assign full    = ram_used[ADDR_W];
    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_valid = (obuf_cnt != 2'd0);
    assign m_data  = obuf0;
    assign empty   = (count == '0);

    assign ram_wea   = push;
    assign ram_addra = wr_ptr;
    assign ram_dina  = push ? s_data : '0;
    assign ram_web   = 1'b0;
    assign ram_addrb = rd_ptr;

    // Buffer slots that stay occupied after this edge; a new read may only
    // be issued if its word is guaranteed a slot when it lands.
    assign slots_claimed = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_issue      = (ram_used != '0) && (slots_claimed < 3'd2);

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here via the leading default), otherwise a latch is inferred.
    always_comb begin
        ram_used_nxt = ram_used;
        if (push && !rd_issue)
            ram_used_nxt = ram_used + 1'b1;
        else if (!push && rd_issue)
            ram_used_nxt = ram_used - 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_used <= '0;
            inflight <= 1'b0;
            count    <= '0;
            obuf_cnt <= 2'd0;
            // NOTE: the buffer data registers are reset too, because the
            // head entry is visible on m_data and must read 0 after reset.
            obuf0    <= '0;
            obuf1    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue)
                rd_ptr <= rd_ptr + 1'b1;
            ram_used <= ram_used_nxt;
            inflight <= rd_issue;
            count    <= count + {{(ADDR_W+1){1'b0}}, push}
                              - {{(ADDR_W+1){1'b0}}, pop};

            // In-order skid buffer: obuf0 is always the oldest word.
            case ({pop, inflight})
                2'b01: begin
                    if (obuf_cnt == 2'd0)
                        obuf0 <= ram_doutb;
                    else
                        obuf1 <= ram_doutb;
                    obuf_cnt <= obuf_cnt + 2'd1;
                end
                2'b10: begin
                    // With one entry left obuf0 keeps its value so m_data
                    // holds the last word while m_valid is low.
                    if (obuf_cnt == 2'd2)
                        obuf0 <= obuf1;
                    obuf_cnt <= obuf_cnt - 2'd1;
                end
                2'b11: begin
                    if (obuf_cnt == 2'd2) begin
                        obuf0 <= obuf1;
                        obuf1 <= ram_doutb;
                    end else begin
                        obuf0 <= ram_doutb;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DPRAM_FIFO_AFULL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            almost_full <= 1'b0;
        else
            almost_full <= (ram_used_nxt >= (ADDR_W+1)'(AF_LEVEL));
    end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed testbench for dpram_fifo_ctrl with a behavioural 16 x 8
// dual-port RAM (write on the edge, registered read on port B).
module tb_dpram_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [DATA_W-1:0] ram_dina;
    logic              ram_web;
    logic [ADDR_W-1:0] ram_addrb;
    logic [DATA_W-1:0] ram_doutb;
    logic              full;
    logic              empty;
    logic [ADDR_W+1:0] count;
`ifdef DPRAM_FIFO_AFULL_EN
    logic              almost_full;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_web   (ram_web),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb),
        .full      (full),
        .empty     (empty),
        .count     (count)
`ifdef DPRAM_FIFO_AFULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    // Behavioural dual-port RAM.
    logic [DATA_W-1:0] mem [16];
    always @(posedge clk) begin
        if (ram_wea)
            mem[ram_addra] <= ram_dina;
        ram_doutb <= mem[ram_addrb];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pushed;
    int exp_idx;
    logic hold_prev;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

        // ---- Reset, then idle ----
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_wea", ram_wea, 0);
        check("rst_addra", ram_addra, 0);
        check("rst_dina", ram_dina, 0);
        check("rst_web", ram_web, 0);
        check("rst_addrb", ram_addrb, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("idle_s_ready", s_ready, 1);
            check("idle_empty", empty, 1);
            check("idle_m_valid", m_valid, 0);
            check("idle_count", count, 0);
            check("idle_web", ram_web, 0);
            tick();
            #1;
        end
        tick();

        // ---- Single word: 3-cycle push-to-valid ----
        s_valid = 1'b1; s_data = 8'hA5; #1;
        check("single_wea", ram_wea, 1);
        check("single_addra", ram_addra, 0);
        check("single_dina", ram_dina, 8'hA5);
        tick();
        s_valid = 1'b0; #1;
        check("single_addrb", ram_addrb, 0);
        check("single_count", count, 1);
        check("single_empty", empty, 0);
        check("single_valid_c1", m_valid, 0);
        tick(); #1;
        check("single_valid_c2", m_valid, 0);
        tick(); #1;
        check("single_valid_c3", m_valid, 1);
        check("single_data", m_data, 8'hA5);
        tick();
        m_ready = 1'b1; #1;
        tick();
        m_ready = 1'b0; #1;
        check("single_pop_empty", empty, 1);
        check("single_pop_count", count, 0);
        check("single_pop_valid", m_valid, 0);
        check("single_hold_data", m_data, 8'hA5);
        tick();

        // ---- Fill with m_ready = 0: 16 in RAM + 2 in the buffer ----
        for (int k = 0; k < 18; k++) begin
            s_valid = 1'b1; s_data = 8'(k); #1;
            check("fill_s_ready", s_ready, 1);
            check("fill_wea", ram_wea, 1);
            check("fill_addra", ram_addra, (1 + k) % 16);
`ifdef DPRAM_FIFO_AFULL_EN
            if (k >= 1)
                check("fill_afull", almost_full, (k >= 14) ? 1 : 0);
`endif
            tick();
        end
        s_valid = 1'b0; #1;
        check("fill_full", full, 1);
        check("fill_s_ready_low", s_ready, 0);
        check("fill_count", count, 18);
        check("fill_head_valid", m_valid, 1);
        check("fill_head_data", m_data, 8'h00);
`ifdef DPRAM_FIFO_AFULL_EN
        check("fill_afull_end", almost_full, 1);
`endif
        tick();
        // A push attempt while full is ignored.
        s_valid = 1'b1; s_data = 8'h99; #1;
        check("full_no_wea", ram_wea, 0);
        tick();
        s_valid = 1'b0; #1;
        check("full_count_kept", count, 18);
        tick();

        // ---- Drain: one word per cycle, in order ----
        m_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            check("drain_valid", m_valid, 1);
            check("drain_data", m_data, i);
            tick();
        end
        m_ready = 1'b0; #1;
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        check("drain_full", full, 0);
        check("drain_valid_low", m_valid, 0);
        tick();

        // ---- Streaming 40 words across the pointer wrap ----
        m_ready = 1'b1;
        for (int c = 0; c < 45; c++) begin
            s_valid = (c < 40); s_data = 8'(8'h40 + c); #1;
            if (c < 40) begin
                check("stream_wea", ram_wea, 1);
                check("stream_addra", ram_addra, (3 + c) % 16);
            end
            if (c >= 1 && c <= 40)
                check("stream_addrb", ram_addrb, (2 + c) % 16);
            if (c >= 3 && c < 43) begin
                check("stream_valid", m_valid, 1);
                check("stream_data", m_data, 8'h40 + c - 3);
            end else begin
                check("stream_idle", m_valid, 0);
            end
            tick();
        end
        m_ready = 1'b0; #1;
        check("stream_count", count, 0);
        tick();

        // ---- Backpressure: m_ready toggles every cycle ----
        pushed = 0; exp_idx = 0; hold_prev = 1'b0;
        for (int cyc = 0; cyc < 100 && exp_idx < 20; cyc++) begin
            s_valid = (pushed < 20); s_data = 8'(8'h80 + pushed);
            m_ready = ((cyc % 2) == 1); #1;
            if (hold_prev)
                check("bp_hold_valid", m_valid, 1);
            if (m_valid)
                check("bp_data", m_data, 8'h80 + exp_idx);
            hold_prev = m_valid && !m_ready;
            if (m_valid && m_ready)
                exp_idx++;
            if (s_valid && s_ready)
                pushed++;
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b0; #1;
        check("bp_all_out", exp_idx, 20);
        check("bp_empty", empty, 1);
        tick();

        // ---- Mid-operation reset with a read in flight ----
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1; s_data = 8'(8'hC0 + k); #1;
            if (k == 0)
                check("mid_addra", ram_addra, 15);
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1; #1;
        check("mid_head_c0", m_data, 8'hC0);
        tick();
        m_ready = 1'b0; #1;
        check("mid_count5", count, 5);
        check("mid_head_c1", m_data, 8'hC1);
        #2;
        rst = 1'b1; #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_addrb", ram_addrb, 0);
        tick();
        rst = 1'b0;
        tick();
        s_valid = 1'b1; s_data = 8'hD7; #1;
        check("post_rst_addra", ram_addra, 0);
        tick();
        s_valid = 1'b0; #1;
        check("post_rst_c1", m_valid, 0);
        tick(); #1;
        check("post_rst_c2", m_valid, 0);
        tick(); #1;
        check("post_rst_valid", m_valid, 1);
        check("post_rst_data", m_data, 8'hD7);
        check("post_rst_count", count, 1);
        tick();
        m_ready = 1'b1; #1;
        tick();
        m_ready = 1'b0; #1;
        check("post_rst_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
